// File: rtl/tick_cd_pkg.sv
// Shared types and constants for the tick_countdown timer: FSM states,
// the BCD digit type and a helper that clamps loaded digits.
`timescale 1ns/1ps
package tick_cd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit: load has priority, otherwise a borrow-in
// decrements, wrapping 0 -> 9 and raising borrow-out.
`timescale 1ns/1ps
module bcd_digit_dn
    import tick_cd_pkg::*;
#(
    parameter bcd_t RESET_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic [3:0] value_next,
    output logic       borrow_out
);

    bcd_t value_reg;

    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = load_val;
        end else if (borrow_in) begin
            value_next = (value_reg == 4'd0) ? BCD_MAX : value_reg - 4'd1;
        end
    end

    assign borrow_out = borrow_in && !load && (value_reg == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= RESET_VAL;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/tick_countdown.sv
// Countdown timer in BCD seconds.tenths driven by an external 100 ms tick.
// Optional remaining-time warning is built only when TICK_CD_WARN_EN is defined.
`timescale 1ns/1ps
module tick_countdown
    import tick_cd_pkg::*;
#(
    parameter int LOAD_DEFAULT_SECS = 30,
    parameter int WARN_SECS         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       ms100,
    output logic       tick_en,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       done,
    output logic       timeout,
    output logic       warn
);

    localparam bcd_t DEF_TENS = bcd_t'((LOAD_DEFAULT_SECS / 10) % 10);
    localparam bcd_t DEF_ONES = bcd_t'(LOAD_DEFAULT_SECS % 10);

    state_t     state_reg, state_next;
    logic       tick_en_reg, running_reg, done_reg, timeout_reg;
    logic       run_tick, val_zero, zero_next, reach_zero;
    logic [3:0] borrow;
    bcd_t       digit_q   [3];
    bcd_t       digit_n   [3];
    bcd_t       load_val  [3];

    // Digit 0 is tenths, 1 is seconds ones, 2 is seconds tens.
    assign load_val[0] = 4'd0;
    assign load_val[1] = bcd_clamp(load_ones);
    assign load_val[2] = bcd_clamp(load_tens);

    assign run_tick  = (state_reg == RUN) && ms100 && !load;
    assign borrow[0] = run_tick;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            localparam bcd_t RST_VAL = (gi == 2) ? DEF_TENS :
                                       (gi == 1) ? DEF_ONES : 4'd0;
            bcd_digit_dn #(
                .RESET_VAL (RST_VAL)
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .load_val   (load_val[gi]),
                .borrow_in  (borrow[gi]),
                .value      (digit_q[gi]),
                .value_next (digit_n[gi]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    assign val_zero   = (digit_q[2] == 4'd0) && (digit_q[1] == 4'd0) && (digit_q[0] == 4'd0);
    assign zero_next  = (digit_n[2] == 4'd0) && (digit_n[1] == 4'd0) && (digit_n[0] == 4'd0);
    // An underflow out of the tens digit cannot occur from RUN, but would also end the run.
    assign reach_zero = run_tick && (zero_next || borrow[3]);

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = val_zero ? DONE : RUN;
                RUN:     if (reach_zero) state_next = DONE;
                         else if (pause) state_next = PAUSE;
                PAUSE:   if (start) state_next = RUN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            tick_en_reg <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_en_reg <= (state_next == RUN);
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
            timeout_reg <= (state_next == DONE) && (state_reg != DONE);
        end
    end

`ifdef TICK_CD_WARN_EN
    logic warn_reg, warn_next;
    int   secs_next;

    always_comb begin
        secs_next = int'(digit_n[2]) * 10 + int'(digit_n[1]);
        warn_next = ((state_next == RUN) || (state_next == PAUSE))
                    && (secs_next < WARN_SECS) && !zero_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warn_reg <= 1'b0;
        end else begin
            warn_reg <= warn_next;
        end
    end

    assign warn = warn_reg;
`else
    // Folds to a constant 0; keeps the threshold parameter referenced in this build.
    assign warn = 1'b0 && (WARN_SECS >= 0);
`endif

    assign tick_en   = tick_en_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign secs_tens = digit_q[2];
    assign secs_ones = digit_q[1];
    assign tenths    = digit_q[0];

endmodule

// File: tb/tb_tick_countdown.sv
// Scoreboard bench for tick_countdown: a behavioural model in integer tenths
// pushes expected outputs per cycle; they are popped and compared after each edge.
`timescale 1ns/1ps
module tb_tick_countdown;

    localparam int DEF_SECS  = 30;
    localparam int WARN_SECS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, ms100 = 1'b0;
    logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
    logic       tick_en, running, done, timeout, warn;
    logic [3:0] secs_tens, secs_ones, tenths;

    tick_countdown #(
        .LOAD_DEFAULT_SECS (DEF_SECS),
        .WARN_SECS         (WARN_SECS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .ms100     (ms100),
        .tick_en   (tick_en),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .tenths    (tenths),
        .running   (running),
        .done      (done),
        .timeout   (timeout),
        .warn      (warn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] t, o, d;
        logic       te, rn, dn, to, wn;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    mst_t mst = M_IDLE;
    int   rem = DEF_SECS * 10;
    logic mto = 1'b0;
    int   step_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, step_no, obs, exp);
        end
    endtask

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.t  = 4'(rem / 100);
        e.o  = 4'((rem / 10) % 10);
        e.d  = 4'(rem % 10);
        e.te = (mst == M_RUN);
        e.rn = (mst == M_RUN);
        e.dn = (mst == M_DONE);
        e.to = mto;
`ifdef TICK_CD_WARN_EN
        e.wn = ((mst == M_RUN) || (mst == M_PAUSE)) && (rem < WARN_SECS * 10) && (rem > 0);
`else
        e.wn = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_step(input logic l, input logic [3:0] lt, input logic [3:0] lo,
                              input logic s, input logic p, input logic t);
        mto = 1'b0;
        if (l) begin
            rem = clampd(lt) * 100 + clampd(lo) * 10;
            mst = M_IDLE;
        end else begin
            case (mst)
                M_IDLE: if (s) begin
                    if (rem == 0) begin
                        mst = M_DONE;
                        mto = 1'b1;
                    end else begin
                        mst = M_RUN;
                    end
                end
                M_RUN: begin
                    if (t) rem = rem - 1;
                    if (t && rem == 0) begin
                        mst = M_DONE;
                        mto = 1'b1;
                    end else if (p) begin
                        mst = M_PAUSE;
                    end
                end
                M_PAUSE: if (s) mst = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            $display("step %0d %s: %0d%0d.%0d te=%0b run=%0b done=%0b to=%0b warn=%0b",
                     step_no, tag, secs_tens, secs_ones, tenths, tick_en, running, done, timeout, warn);
            check({tag, "_tens"},    secs_tens, e.t);
            check({tag, "_ones"},    secs_ones, e.o);
            check({tag, "_tenths"},  tenths,    e.d);
            check({tag, "_tick_en"}, tick_en,   e.te);
            check({tag, "_running"}, running,   e.rn);
            check({tag, "_done"},    done,      e.dn);
            check({tag, "_timeout"}, timeout,   e.to);
            check({tag, "_warn"},    warn,      e.wn);
        end
    endtask

    task automatic step(input string tag, input logic l, input logic [3:0] lt, input logic [3:0] lo,
                        input logic s, input logic p, input logic t);
        @(negedge clk);
        load = l; load_tens = lt; load_ones = lo; start = s; pause = p; ms100 = t;
        model_step(l, lt, lo, s, p, t);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; ms100 = 1'b0;
        step_no++;
        pop_compare(tag);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        mst = M_IDLE; rem = DEF_SECS * 10; mto = 1'b0;
        sb.push_back(model_out());
        pop_compare("async_rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        sb.push_back(model_out());
        pop_compare("reset");
        @(negedge clk);
        rst = 1'b1;
        step("idle_after_rst", 0, 0, 0, 0, 0, 1);

        // 02.0 down to zero, then DONE ignores start/pause/ticks
        step("load02", 1, 0, 2, 0, 0, 0);
        step("start", 0, 0, 0, 1, 0, 0);
        repeat (20) step("tick", 0, 0, 0, 0, 0, 1);
        repeat (2) step("done_hold", 0, 0, 0, 0, 0, 0);
        step("done_start", 0, 0, 0, 1, 0, 1);
        step("done_pause", 0, 0, 0, 0, 1, 1);

        // load beats start/tick; borrow chain across two digits
        step("load10_start", 1, 1, 0, 1, 0, 1);
        step("start", 0, 0, 0, 1, 0, 0);
        repeat (10) step("tick", 0, 0, 0, 0, 0, 1);

        // pause with simultaneous tick, ticks ignored while paused
        step("load05", 1, 0, 5, 0, 0, 0);
        step("start", 0, 0, 0, 1, 0, 0);
        repeat (3) step("tick", 0, 0, 0, 0, 0, 1);
        step("pause_tick", 0, 0, 0, 0, 1, 1);
        repeat (5) step("paused_tick", 0, 0, 0, 0, 0, 1);
        step("resume", 0, 0, 0, 1, 0, 0);
        step("tick", 0, 0, 0, 0, 0, 1);
        step("run_start_pause", 0, 0, 0, 1, 1, 1);
        step("pause_start_pause", 0, 0, 0, 1, 1, 0);

        // zero start and start/pause priority in IDLE
        step("load00", 1, 0, 0, 0, 0, 0);
        step("start_zero", 0, 0, 0, 1, 0, 1);
        repeat (2) step("done_hold", 0, 0, 0, 0, 0, 0);
        step("load03", 1, 0, 3, 0, 0, 0);
        step("idle_start_pause", 0, 0, 0, 1, 1, 0);

        // warning window from 06.0 to zero
        step("load06", 1, 0, 6, 0, 0, 0);
        step("start", 0, 0, 0, 1, 0, 0);
        repeat (61) step("warn_tick", 0, 0, 0, 0, 0, 1);

        // async reset mid-run at 12.3, then clamped load
        step("load13", 1, 1, 3, 0, 0, 0);
        step("start", 0, 0, 0, 1, 0, 0);
        repeat (7) step("tick", 0, 0, 0, 0, 0, 1);
        async_reset();
        step("post_rst", 0, 0, 0, 0, 0, 0);
        step("load_fc", 1, 4'hF, 4'hC, 0, 0, 0);
        step("start", 0, 0, 0, 1, 0, 0);
        step("tick", 0, 0, 0, 0, 0, 1);

        // random mix
        repeat (200) begin
            logic       l, s, p, t;
            logic [3:0] lt, lo;
            l  = ($urandom_range(0, 15) == 0);
            lt = 4'($urandom_range(0, 15));
            lo = 4'($urandom_range(0, 15));
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 1) == 0);
            step("rand", l, (lt > 4'd3) ? 4'd0 : lt, lo, s, p, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_countdown.md
TICK_COUNTDOWN -- requirements
Module: tick_countdown

Interface
REQ-001 Parameter: LOAD_DEFAULT_SECS, 30, BCD-interpreted seconds value held after reset (00.0 to 99.9 range).
REQ-002 Parameter: WARN_SECS, 5, warning threshold in whole seconds; used only with TICK_CD_WARN_EN.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 load  in  1  one-cycle strobe; capture load_tens/load_ones, tenths := 0.
REQ-006 load_tens, load_ones  in  4 each  BCD seconds to load.
REQ-007 start  in  1  one-cycle strobe; begin or resume countdown.
REQ-008 pause  in  1  one-cycle strobe; freeze countdown.
REQ-009 ms100  in  1  one-cycle 100 ms tick from the tick generator.
REQ-010 tick_en  out  1  enable to the tick generator; high only in RUN.
REQ-011 secs_tens, secs_ones, tenths  out  4 each  remaining time, BCD.
REQ-012 running  out  1  high in RUN.
REQ-013 done  out  1  level, high in DONE.
REQ-014 timeout  out  1  one-cycle pulse on entry to DONE.
REQ-015 warn  out  1  remaining-time warning (TICK_CD_WARN_EN only; else tied 0).

Function
REQ-016 States: IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: start with nonzero value -> RUN; start with 00.0 -> DONE with timeout pulse.
REQ-018 RUN: ms100 decrements the 3-digit BCD value by 0.1 s; result visible the edge after the tick.
REQ-019 Borrow: tenths 0 -> 9 with borrow to secs_ones; secs_ones 0 -> 9 with borrow to secs_tens.
REQ-020 RUN: tick that produces 00.0 -> DONE next edge, timeout high exactly one cycle, value held at 00.0.
REQ-021 RUN: pause -> PAUSE; ms100 in the same cycle is still counted.
REQ-022 PAUSE: value frozen, ms100 ignored; start -> RUN.
REQ-023 DONE: ms100, start, pause ignored; only load or reset leaves DONE.
REQ-024 load in any state -> IDLE, value loaded, tick_en low next edge; load beats start/pause/ms100 in the same cycle.
REQ-025 Load digit > 9 SHALL be clamped to 9.
REQ-026 start and pause in the same cycle in RUN -> pause wins; in IDLE/PAUSE -> start wins.
REQ-027 tick_en low in IDLE/PAUSE/DONE so the generator restarts its 100 ms interval on each resume.
REQ-028 ms100 outside RUN SHALL have no effect.

Reset
REQ-029 rst low asynchronously forces IDLE, value = LOAD_DEFAULT_SECS, tenths = 0, tick_en/running/done/timeout/warn = 0.
REQ-030 Reset mid-RUN discards remaining time; deassertion leaves IDLE with no spurious timeout.

Configuration
REQ-031 Macro TICK_CD_WARN_EN defined: warn high in RUN or PAUSE while remaining time < WARN_SECS.0 s and > 00.0; low otherwise.
REQ-032 Macro TICK_CD_WARN_EN undefined: warn SHALL be constant 0 and no comparator logic SHALL be synthesised.

Structure
REQ-033 Shared package tick_cd_pkg: state enum (IDLE, RUN, PAUSE, DONE), 4-bit BCD digit type, constant BCD_MAX = 9.
REQ-034 Sub-module bcd_digit_dn: one BCD digit, decrement-with-borrow-in/borrow-out, load; instantiated three times.

Verification
REQ-035 Reset, load 02, start, 20 ticks -> 00.0; timeout one cycle on the 20th tick's following edge; done high; tick_en low.
REQ-036 Load 10, start, 1 tick -> 09.9; 9 more ticks -> 09.0 (borrow chain across two digits checked).
REQ-037 Load 05, start, 3 ticks, pause with simultaneous tick -> 04.6 frozen; 5 ticks ignored; start, 1 tick -> 04.5.
REQ-038 Load 00, start -> DONE with single timeout pulse, tick_en never high.
REQ-039 Mid-RUN at 12.3, assert rst -> immediate IDLE, 30.0, all outputs 0; load 0xF/0xC digits -> 99.0.
REQ-040 With TICK_CD_WARN_EN, WARN_SECS=5: load 06, start, warn low until value 04.9, high through 00.1, low at 00.0.
